// File: rtl/framebuffer_dbuf_if.sv
// Renderer write, swap handshake and scanout read signals of the double-buffered framebuffer.
// The master drives requests and coordinates; the slave is the framebuffer itself.
interface framebuffer_dbuf_if #(
  parameter int unsigned X_W   = 9,
  parameter int unsigned Y_W   = 8,
  parameter int unsigned PIX_W = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [X_W-1:0]   wr_x;
  logic [Y_W-1:0]   wr_y;
  logic [PIX_W-1:0] wr_pix;
  logic             wr_drop;
  logic             swap_req;
  logic             vblank;
  logic             swap_done;
  logic             front_sel;
  logic             rd_en;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic [PIX_W-1:0] rd_pix;
  logic             rd_valid;
  logic             clear_busy;

  modport master (
    output wr_valid, wr_x, wr_y, wr_pix, swap_req, vblank, rd_en, rd_x, rd_y,
    input  wr_ready, wr_drop, swap_done, front_sel, rd_pix, rd_valid, clear_busy
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_pix, swap_req, vblank, rd_en, rd_x, rd_y,
    output wr_ready, wr_drop, swap_done, front_sel, rd_pix, rd_valid, clear_busy
  );
endinterface

// File: rtl/framebuffer_dbuf.sv
// Double-buffered palette framebuffer: the renderer writes the back bank, scanout reads the front.
// Banks swap only in vblank. Define FB_CLEAR_EN to fill the new back bank with CLEAR_COLOR per swap.
module framebuffer_dbuf #(
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 200,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned CLEAR_COLOR = 0
) (
  input logic               clk,
  input logic               rst,
  framebuffer_dbuf_if.slave fb
);
  localparam int unsigned DEPTH = H_RES * V_RES;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned MW    = $clog2(2 * DEPTH);
  localparam logic [X_W:0] XLIM = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0] YLIM = (Y_W + 1)'(V_RES);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StPending, StClear} state_e;
`else
  typedef enum logic {StIdle, StPending} state_e;
`endif

  // Bank 1 occupies the upper half of one flat array so a single RAM is inferred.
  function automatic logic [MW-1:0] mem_addr(input logic bank, input logic [X_W-1:0] x,
                                             input logic [Y_W-1:0] y, input logic in_range);
    logic [AW-1:0] lin;
    lin = AW'(y) * AW'(H_RES) + AW'(x);
    if (!in_range) lin = '0;
    return (bank ? MW'(DEPTH) : MW'(0)) + MW'(lin);
  endfunction

  state_e state_q, state_d;
  logic   front_q, front_d;
  logic   swap_done_q, swap_done_d;
`ifdef FB_CLEAR_EN
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Write pipeline
  logic             accept;
  logic             w1_valid_q, w1_in_q, w1_bank_q;
  logic [X_W-1:0]   w1_x_q;
  logic [Y_W-1:0]   w1_y_q;
  logic [PIX_W-1:0] w1_pix_q;
  logic             wr_drop_q;

  assign accept = fb.wr_valid && fb.wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1_valid_q <= 1'b0;
      w1_in_q    <= 1'b0;
      w1_bank_q  <= 1'b0;
      w1_x_q     <= '0;
      w1_y_q     <= '0;
      w1_pix_q   <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      w1_valid_q <= accept;
      if (accept) begin
        w1_x_q    <= fb.wr_x;
        w1_y_q    <= fb.wr_y;
        w1_pix_q  <= fb.wr_pix;
        w1_in_q   <= ({1'b0, fb.wr_x} < XLIM) && ({1'b0, fb.wr_y} < YLIM);
        w1_bank_q <= ~front_q;
      end
      wr_drop_q <= w1_valid_q && !w1_in_q;
    end
  end

  // Memory write port, shared with the clear engine when present
  logic [PIX_W-1:0] mem [2*DEPTH];
  logic             mem_we;
  logic [MW-1:0]    mem_waddr;
  logic [PIX_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = w1_valid_q && w1_in_q;
    mem_waddr = mem_addr(w1_bank_q, w1_x_q, w1_y_q, w1_in_q);
    mem_wdata = w1_valid_q ? w1_pix_q : PIX_W'(CLEAR_COLOR);
`ifdef FB_CLEAR_EN
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = (~front_q ? MW'(DEPTH) : MW'(0)) + MW'(clr_cnt_q);
      mem_wdata = PIX_W'(CLEAR_COLOR);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read pipeline: bank is captured with the request so a swap cannot redirect it
  logic             r1_valid_q, r1_in_q, r1_bank_q;
  logic [X_W-1:0]   r1_x_q;
  logic [Y_W-1:0]   r1_y_q;
  logic [MW-1:0]    raddr;
  logic             rd_valid_q;
  logic [PIX_W-1:0] rd_pix_q;

  assign raddr = mem_addr(r1_bank_q, r1_x_q, r1_y_q, r1_in_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid_q <= 1'b0;
      r1_in_q    <= 1'b0;
      r1_bank_q  <= 1'b0;
      r1_x_q     <= '0;
      r1_y_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_pix_q   <= '0;
    end else begin
      r1_valid_q <= fb.rd_en;
      if (fb.rd_en) begin
        r1_x_q    <= fb.rd_x;
        r1_y_q    <= fb.rd_y;
        r1_in_q   <= ({1'b0, fb.rd_x} < XLIM) && ({1'b0, fb.rd_y} < YLIM);
        r1_bank_q <= front_q;
      end
      rd_valid_q <= r1_valid_q;
      if (r1_valid_q) rd_pix_q <= r1_in_q ? mem[raddr] : '0;
    end
  end

  // Swap control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      swap_done_q <= swap_done_d;
`ifdef FB_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_done_d = 1'b0;
`ifdef FB_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (fb.swap_req) state_d = StPending;
      end
      StPending: begin
        // Wait for the last accepted write to land so it hits the old back bank.
        if (fb.vblank && !w1_valid_q) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
`ifdef FB_CLEAR_EN
          state_d     = StClear;
          clr_cnt_d   = '0;
`else
          state_d     = StIdle;
`endif
        end
      end
`ifdef FB_CLEAR_EN
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign fb.wr_ready  = (state_q == StIdle) && !rst;
  assign fb.wr_drop   = wr_drop_q;
  assign fb.swap_done = swap_done_q;
  assign fb.front_sel = front_q;
  assign fb.rd_valid  = rd_valid_q;
  assign fb.rd_pix    = rd_pix_q;
`ifdef FB_CLEAR_EN
  assign fb.clear_busy = (state_q == StClear);
`else
  assign fb.clear_busy = 1'b0;
`endif
endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Self-checking bench for framebuffer_dbuf: directed scenarios plus randomized traffic, all
// compared every cycle against a bank-array model of the framebuffer. Honours FB_CLEAR_EN.
module tb_framebuffer_dbuf;
  localparam int unsigned H_RES       = 320;
  localparam int unsigned V_RES       = 200;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned X_W         = 9;
  localparam int unsigned Y_W         = 8;
  localparam int unsigned CLEAR_COLOR = 0;
  localparam int unsigned DEPTH       = H_RES * V_RES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  framebuffer_dbuf_if #(.X_W(X_W), .Y_W(Y_W), .PIX_W(PIX_W)) fb ();

  framebuffer_dbuf #(
    .H_RES(H_RES), .V_RES(V_RES), .PIX_W(PIX_W), .X_W(X_W), .Y_W(Y_W),
    .CLEAR_COLOR(CLEAR_COLOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fb (fb)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input int x, input int y);
    return (x < int'(H_RES)) && (y < int'(V_RES));
  endfunction

  function automatic int lin(input int x, input int y);
    return y * int'(H_RES) + x;
  endfunction

  // Model: two bank arrays plus the visible state of the swap handshake.
  logic [PIX_W-1:0] m_mem   [2][DEPTH];
  bit               m_known [2][DEPTH];
  bit               m_front, m_pend, m_clr;
  int unsigned      m_clr_idx;
  bit               w1_v, w1_b, r1_v, r1_b;
  int               w1_x, w1_y, r1_x, r1_y;
  logic [PIX_W-1:0] w1_pix;
  bit               e_drop, e_done, e_rvalid, e_rknown;
  logic [PIX_W-1:0] e_rpix;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_front <= 1'b0; m_pend <= 1'b0; m_clr <= 1'b0; m_clr_idx <= 0;
      w1_v <= 1'b0; r1_v <= 1'b0;
      e_drop <= 1'b0; e_done <= 1'b0; e_rvalid <= 1'b0; e_rknown <= 1'b1; e_rpix <= '0;
    end else begin
      e_rvalid <= r1_v;
      if (r1_v) begin
        if (in_range(r1_x, r1_y)) begin
          e_rpix   <= m_mem[r1_b][lin(r1_x, r1_y)];
          e_rknown <= m_known[r1_b][lin(r1_x, r1_y)];
        end else begin
          e_rpix   <= '0;
          e_rknown <= 1'b1;
        end
      end
      e_drop <= w1_v && !in_range(w1_x, w1_y);
      if (w1_v && in_range(w1_x, w1_y)) begin
        m_mem[w1_b][lin(w1_x, w1_y)]   <= w1_pix;
        m_known[w1_b][lin(w1_x, w1_y)] <= 1'b1;
      end
      e_done <= 1'b0;
      if (m_clr) begin
        m_mem[!m_front][m_clr_idx]   <= PIX_W'(CLEAR_COLOR);
        m_known[!m_front][m_clr_idx] <= 1'b1;
        m_clr_idx <= m_clr_idx + 1;
        if (m_clr_idx == DEPTH - 1) m_clr <= 1'b0;
      end else if (m_pend) begin
        if (fb.vblank && !w1_v) begin
          m_front <= !m_front;
          e_done  <= 1'b1;
          m_pend  <= 1'b0;
`ifdef FB_CLEAR_EN
          m_clr     <= 1'b1;
          m_clr_idx <= 0;
`endif
        end
      end else if (fb.swap_req) begin
        m_pend <= 1'b1;
      end
      w1_v   <= fb.wr_valid && !m_pend && !m_clr;
      w1_x   <= int'(fb.wr_x);
      w1_y   <= int'(fb.wr_y);
      w1_pix <= fb.wr_pix;
      w1_b   <= !m_front;
      r1_v   <= fb.rd_en;
      r1_x   <= int'(fb.rd_x);
      r1_y   <= int'(fb.rd_y);
      r1_b   <= m_front;
    end
  end

  // Per-cycle compare, 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    chk("wr_ready",   fb.wr_ready,   !rst && !m_pend && !m_clr);
    chk("wr_drop",    fb.wr_drop,    e_drop);
    chk("swap_done",  fb.swap_done,  e_done);
    chk("front_sel",  fb.front_sel,  m_front);
    chk("rd_valid",   fb.rd_valid,   e_rvalid);
    chk("clear_busy", fb.clear_busy, m_clr);
    if (e_rvalid && e_rknown) chk("rd_pix", fb.rd_pix, e_rpix);
  end

  function automatic logic [X_W-1:0] rnd_x();
    if ($urandom_range(0, 9) == 0) return X_W'($urandom_range(H_RES, (1 << X_W) - 1));
    return X_W'($urandom_range(0, 15));
  endfunction

  function automatic logic [Y_W-1:0] rnd_y();
    if ($urandom_range(0, 9) == 0) return Y_W'($urandom_range(V_RES, (1 << Y_W) - 1));
    return Y_W'($urandom_range(0, 3));
  endfunction

  task automatic write_px(input int x, input int y, input int pix);
    fb.wr_valid = 1'b1;
    fb.wr_x = X_W'(x); fb.wr_y = Y_W'(y); fb.wr_pix = PIX_W'(pix);
    @(negedge clk);
    fb.wr_valid = 1'b0;
  endtask

  task automatic do_swap(input string name);
    bit seen;
    fb.vblank   = 1'b1;
    fb.swap_req = 1'b1;
    @(negedge clk);
    fb.swap_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fb.swap_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic read_px(input string name, input int x, input int y, input int exp);
    bit v1;
    fb.rd_en = 1'b1;
    fb.rd_x = X_W'(x); fb.rd_y = Y_W'(y);
    @(negedge clk);
    fb.rd_en = 1'b0;
    v1 = fb.rd_valid;
    @(negedge clk);
    chk({name, "_latency"}, {v1, fb.rd_valid}, 2'b01);
    chk(name, fb.rd_pix, exp);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit any;
    int n, busy;
    logic [PIX_W-1:0] res [8];

    fb.wr_valid = 1'b0; fb.wr_x = '0; fb.wr_y = '0; fb.wr_pix = '0;
    fb.swap_req = 1'b0; fb.vblank = 1'b0;
    fb.rd_en = 1'b0; fb.rd_x = '0; fb.rd_y = '0;

    repeat (3) @(negedge clk);
    chk("rst_wr_ready",  fb.wr_ready,   1'b0);
    chk("rst_front",     fb.front_sel,  1'b0);
    chk("rst_rd_valid",  fb.rd_valid,   1'b0);
    chk("rst_swap_done", fb.swap_done,  1'b0);
    chk("rst_wr_drop",   fb.wr_drop,    1'b0);
    chk("rst_clear",     fb.clear_busy, 1'b0);
    chk("rst_rd_pix",    fb.rd_pix,     8'h00);
    rst = 1'b0;
    #1;
    chk("release_wr_ready", fb.wr_ready, 1'b1);
    @(negedge clk);

`ifndef FB_CLEAR_EN
    // Write, swap into view, read back with two-cycle latency.
    write_px(10, 20, 8'h5A);
    do_swap("swap1");
    chk("swap1_front", fb.front_sel, 1'b1);
    read_px("rd_10_20", 10, 20, 8'h5A);

    // (320,5) aliases the linear address of (0,6) and must be dropped, not written.
    write_px(0, 6, 8'h33);
    fb.wr_valid = 1'b1; fb.wr_x = X_W'(320); fb.wr_y = Y_W'(5); fb.wr_pix = 8'hEE;
    @(negedge clk);
    fb.wr_valid = 1'b0;
    chk("drop_early", fb.wr_drop, 1'b0);
    @(negedge clk);
    chk("drop_pulse", fb.wr_drop, 1'b1);
    @(negedge clk);
    chk("drop_end", fb.wr_drop, 1'b0);
    do_swap("swap2");
    read_px("rd_0_6", 0, 6, 8'h33);
    read_px("rd_400_0", 400, 0, 8'h00);

    // Swap held off by vblank=0.
    fb.vblank = 1'b0; fb.swap_req = 1'b1;
    @(negedge clk);
    fb.swap_req = 1'b0;
    repeat (100) @(negedge clk);
    chk("hold_wr_ready", fb.wr_ready, 1'b0);
    chk("hold_front", fb.front_sel, 1'b0);
    fb.vblank = 1'b1;
    @(negedge clk);
    chk("vbl_swap_done", fb.swap_done, 1'b1);
    chk("vbl_front", fb.front_sel, 1'b1);
    chk("vbl_wr_ready", fb.wr_ready, 1'b1);

    // Streaming read with a swap mid-burst: reads 0..4 see the old front, 5..7 the new one.
    for (int i = 0; i < 8; i++) write_px(i, 0, 8'h20 + i);
    do_swap("swap4");
    for (int i = 0; i < 8; i++) write_px(i, 0, 8'h30 + i);
    repeat (2) @(negedge clk);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (fb.rd_valid && n < 8) begin
        res[n] = fb.rd_pix;
        n++;
      end
      fb.rd_en    = (k < 8);
      fb.rd_x     = X_W'(k);
      fb.rd_y     = '0;
      fb.swap_req = (k == 3);
      @(negedge clk);
    end
    chk("burst_count", n, 8);
    for (int i = 0; i < 8; i++) chk("burst_pix", res[i], (i <= 4) ? 8'h20 + i : 8'h30 + i);
    chk("burst_front", fb.front_sel, 1'b1);

    // Reset while a swap is pending.
    fb.vblank = 1'b0; fb.swap_req = 1'b1;
    @(negedge clk);
    fb.swap_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fb.vblank = 1'b1;
    #1;
    chk("pend_rst_front", fb.front_sel, 1'b0);
    chk("pend_rst_wr_ready", fb.wr_ready, 1'b0);
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (fb.swap_done || fb.wr_ready) any = 1'b1;
    end
    rst = 1'b0;
    #1;
    chk("pend_rel_wr_ready", fb.wr_ready, 1'b1);
    repeat (5) begin
      @(negedge clk);
      if (fb.swap_done || fb.front_sel) any = 1'b1;
    end
    chk("pend_rst_no_swap", any, 1'b0);
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      fb.wr_valid = 1'($urandom_range(0, 1));
      fb.wr_x     = rnd_x();
      fb.wr_y     = rnd_y();
      fb.wr_pix   = PIX_W'($urandom);
      fb.rd_en    = 1'($urandom_range(0, 1));
      fb.rd_x     = rnd_x();
      fb.rd_y     = rnd_y();
`ifdef FB_CLEAR_EN
      fb.swap_req = 1'b0;
`else
      fb.swap_req = ($urandom_range(0, 39) == 0);
`endif
      if ($urandom_range(0, 19) == 0) fb.vblank = !fb.vblank;
      @(negedge clk);
    end
    fb.wr_valid = 1'b0; fb.rd_en = 1'b0; fb.swap_req = 1'b0;
    repeat (4) @(negedge clk);

`ifdef FB_CLEAR_EN
    // Clear engine: one full bank fill, then view the cleared bank.
    write_px(10, 3, 8'h77);
    do_swap("clr_swap1");
    busy = 0;
    for (int i = 0; i < 70000 && fb.clear_busy; i++) begin
      busy++;
      @(negedge clk);
    end
    chk("clear_cycles", busy, DEPTH);
    do_swap("clr_swap2");
    read_px("clr_0_0", 0, 0, CLEAR_COLOR);
    read_px("clr_10_3", 10, 3, CLEAR_COLOR);
    read_px("clr_319_199", 319, 199, CLEAR_COLOR);
    read_px("clr_5_1", 5, 1, CLEAR_COLOR);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/framebuffer_dbuf.md
Name: framebuffer_dbuf

Overview:
Parametrised double-buffered framebuffer for the Doom graphics path. The renderer writes palette-indexed pixels by (x,y) into the back bank while VGA scanout reads the front bank. Banks swap on request, but only during vertical blank, so the display never tears. It replaces the single-bank framebuffer and adds pipelined addressing, coordinate bounds checking and a swap handshake.

Parameters:
H_RES, 320, visible pixels per line
V_RES, 200, visible lines per frame
PIX_W, 8, bits per pixel (palette index)
X_W, 9, width of x coordinates; must satisfy 2^X_W >= H_RES
Y_W, 8, width of y coordinates; must satisfy 2^Y_W >= V_RES
CLEAR_COLOR, 0, fill value used by the optional clear engine

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_valid  in  1  renderer pixel write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_x  in  X_W  write x coordinate
wr_y  in  Y_W  write y coordinate
wr_pix  in  PIX_W  write pixel value
wr_drop  out  1  one-cycle pulse when an accepted write was out of range
swap_req  in  1  one-cycle pulse: back frame is complete
vblank  in  1  vertical blank from the VGA timing block
swap_done  out  1  one-cycle pulse on the cycle front_sel toggles
front_sel  out  1  index of the bank currently being displayed
rd_en  in  1  scanout read request
rd_x  in  X_W  read x coordinate
rd_y  in  Y_W  read y coordinate
rd_pix  out  PIX_W  read data
rd_valid  out  1  rd_pix is valid
clear_busy  out  1  clear engine active (0 when FB_CLEAR_EN is undefined)

Behaviour:
- Storage: two banks of H_RES*V_RES words, PIX_W bits each, inferred as block RAM. Linear address = y*H_RES + x.
- Reset values: front_sel=0, state=IDLE, wr_ready=0 while rst is high and 1 in the first cycle after release, wr_drop=0, swap_done=0, rd_valid=0, rd_pix=0, clear_busy=0.
- Write path, 2 stages:
  - Stage 1 registers x, y, pix, range flag (x<H_RES && y<V_RES) and the bank (~front_sel) on acceptance.
  - Stage 2 writes the RAM.
  - An out-of-range write is accepted but not written; wr_drop pulses in stage 2.
  - The bank is latched at acceptance, so in-flight writes complete into the bank that was the back bank when they were accepted.
- Read path, latency 2: rd_en registers x, y and front_sel; rd_pix and rd_valid appear 2 cycles later.
  - An out-of-range read returns 0 with rd_valid=1.
  - Back-to-back reads give one result per cycle.
  - Because the bank is latched per read, a swap does not corrupt reads already in flight.
- Swap FSM:
  - IDLE: swap_req -> PENDING. Set wr_ready=0.
  - PENDING: vblank=1 and the write pipeline is empty -> toggle front_sel, pulse swap_done, go to IDLE (or CLEAR when FB_CLEAR_EN is defined). Otherwise remain in PENDING with wr_ready=0.
  - swap_req is ignored outside IDLE.
  - Minimum latency from swap_req to swap_done is 1 cycle, even when vblank is already high.
  - A swap_req arriving in the same cycle as a write acceptance is legal; that write lands in the old back bank.
- Reset asserted mid-operation returns the block immediately to the reset values. RAM contents are not cleared.

Optional Feature:
- Macro: FB_CLEAR_EN.
- When defined:
  - After each swap the FSM enters CLEAR.
  - A counter writes CLEAR_COLOR to every address of the new back bank at one word per cycle (H_RES*V_RES cycles).
  - clear_busy=1 and wr_ready=0 throughout, then the FSM returns to IDLE.
  - A swap_req during CLEAR is ignored.
- When undefined: there is no CLEAR state, clear_busy is tied to 0, and the back bank keeps its stale contents.

Test Plan:
- Write (10,20)=0x5A, then swap_req with vblank=1 -> swap_done pulses and front_sel=1; read (10,20) -> rd_pix=0x5A with rd_valid exactly 2 cycles after rd_en.
- Write x=320,y=5 -> wr_drop pulses 2 cycles after acceptance; a read of (0,6) is unchanged. Read (400,0) -> rd_pix=0, rd_valid=1.
- swap_req with vblank=0 for 100 cycles -> wr_ready=0 and front_sel unchanged; raise vblank -> swap_done on the next cycle, then wr_ready=1.
- Issue a streaming read of (0..7,0) and swap mid-burst -> every result comes from the bank that was front when its rd_en was issued.
- Assert rst while in PENDING -> front_sel=0, swap_done never pulses, wr_ready=0 during reset and 1 after release.
- FB_CLEAR_EN with CLEAR_COLOR=0x00: swap -> clear_busy high for exactly 64000 cycles; after the next swap every sampled pixel of the old back bank reads 0x00.
